// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: fetch port (m0), load/store port (m1) and memory side.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_addr,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer for the single-port data memory.
// Sub-word stores are done as read-modify-write (IDLE read, RMW_WR write).
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: m1 fixed priority.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {IDLE, RMW_WR} state_e;

  state_e      state_q, state_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_data_q, rmw_data_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic        er0_q, er0_d, er1_q, er1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
`ifdef MEM_ARB_RR_EN
  logic        last_q, last_d;   // 1 = m1 granted last
`endif

  logic        sel1;
  logic [31:0] win_addr;
  logic        win_we;
  logic        oor;
  logic        resp_v;
  logic        resp_to1;
  logic        resp_e;
  logic [31:0] resp_d;

  // winner selection among pending requesters
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (bus.m0_req && bus.m1_req) sel1 = ~last_q;
    else                          sel1 = bus.m1_req;
`else
    sel1 = bus.m1_req;
`endif
    win_addr = sel1 ? bus.m1_addr : bus.m0_addr;
    win_we   = sel1 & bus.m1_we;
    oor      = (win_addr > MAX_ADDR);
  end

  // next state, memory drive and response routing
  always_comb begin
    state_d       = state_q;
    rmw_addr_d    = rmw_addr_q;
    rmw_data_d    = rmw_data_q;
    resp_v        = 1'b0;
    resp_to1      = sel1;
    resp_e        = 1'b0;
    resp_d        = '0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
`ifdef MEM_ARB_RR_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          bus.m0_gnt = ~sel1;
          bus.m1_gnt = sel1;
`ifdef MEM_ARB_RR_EN
          last_d     = sel1;
`endif
          if (oor) begin
            resp_v = 1'b1;
            resp_e = 1'b1;
          end else if (!win_we) begin
            bus.mem_addr = win_addr;
            resp_v       = 1'b1;
            resp_d       = bus.mem_rdata;
          end else if (bus.m1_size[1]) begin
            bus.mem_wen   = 1'b1;
            bus.mem_addr  = win_addr;
            bus.mem_wdata = bus.m1_wdata;
            resp_v        = 1'b1;
          end else begin
            bus.mem_addr = win_addr;
            rmw_addr_d   = win_addr;
            rmw_data_d   = bus.m1_size[0] ? {bus.mem_rdata[31:16], bus.m1_wdata[15:0]}
                                          : {bus.mem_rdata[31:8],  bus.m1_wdata[7:0]};
            state_d      = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = rmw_addr_q;
        bus.mem_wdata = rmw_data_q;
        resp_v        = 1'b1;
        resp_to1      = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rv0_d = resp_v & ~resp_to1;
    rv1_d = resp_v &  resp_to1;
    er0_d = resp_e & ~resp_to1;
    er1_d = resp_e &  resp_to1;
    rd0_d = resp_to1 ? '0 : resp_d;
    rd1_d = resp_to1 ? resp_d : '0;
  end

  // state and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      er0_q      <= 1'b0;
      er1_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      er0_q      <= er0_d;
      er1_q      <= er1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.m0_rvalid = rv0_q;
  assign bus.m0_rdata  = rd0_q;
  assign bus.m0_err    = er0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.m1_rdata  = rd1_q;
  assign bus.m1_err    = er1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory, byte-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_BYTES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];
  int n_pass  = 0;
  int n_total = 0;
  int g0 = 0, g1 = 0, v0 = 0, v1 = 0, both_cnt = 0, wen_cnt = 0;

  // memory: combinational read, 4-byte write on clock
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_addr <= 32'd28)
      for (int i = 0; i < 4; i++) bus.mem_rdata[8*i +: 8] = mem[int'(bus.mem_addr) + i];
  end

  always @(posedge clk) begin
    if (bus.mem_wen && bus.mem_addr <= 32'd28)
      for (int i = 0; i < 4; i++) mem[int'(bus.mem_addr) + i] <= bus.mem_wdata[8*i +: 8];
  end

  // grant / response / write activity counters
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.m0_gnt) g0++;
      if (bus.m1_gnt) g1++;
      if (bus.m0_rvalid) v0++;
      if (bus.m1_rvalid) v1++;
      if (bus.m0_gnt && bus.m1_gnt) both_cnt++;
      if (bus.mem_wen) wen_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  task automatic m1_xact(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned nb, exp_lat, waited, lat;
    logic [31:0] exp_rd;
    logic exp_err, exp_wen, wen_at_gnt, got;
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = (a > 32'd28);
    exp_rd  = '0;
    exp_lat = 1;
    exp_wen = 1'b0;
    if (!exp_err) begin
      if (!we) exp_rd = ref_word(a);
      else begin
        for (int unsigned i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
        exp_lat = (nb == 4) ? 1 : 2;
        exp_wen = (nb == 4);
      end
    end
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_size = sz; bus.m1_addr = a; bus.m1_wdata = wd;
    #1;
    waited = 0;
    while (!bus.m1_gnt && waited < 20) begin @(negedge clk); #1; waited++; end
    n_total++;
    if (bus.m1_gnt !== 1'b1) $display("FAIL m1_gnt a=%0d: got %b want 1", a, bus.m1_gnt); else n_pass++;
    wen_at_gnt = bus.mem_wen;
    @(posedge clk); #1;
    bus.m1_req = 1'b0;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    while (!got && lat < 4) begin
      @(negedge clk); lat++;
      if (bus.m1_rvalid) begin got = 1'b1; rd = bus.m1_rdata; er = bus.m1_err; end
    end
    n_total++;
    if (lat != exp_lat) $display("FAIL m1_lat we=%b sz=%0d a=%0d: got %0d want %0d", we, sz, a, lat, exp_lat); else n_pass++;
    n_total++;
    if (rd !== exp_rd) $display("FAIL m1_rdata a=%0d: got %h want %h", a, rd, exp_rd); else n_pass++;
    n_total++;
    if (er !== exp_err) $display("FAIL m1_err a=%0d: got %b want %b", a, er, exp_err); else n_pass++;
    n_total++;
    if (wen_at_gnt !== exp_wen) $display("FAIL m1_wen_gnt a=%0d: got %b want %b", a, wen_at_gnt, exp_wen); else n_pass++;
  endtask

  task automatic m0_fetch(input logic [31:0] a, output logic [31:0] rd, output logic er);
    int unsigned waited, lat;
    logic [31:0] exp_rd;
    logic exp_err, wen_at_gnt, got;
    exp_err = (a > 32'd28);
    exp_rd  = exp_err ? 32'h0 : ref_word(a);
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_addr = a;
    #1;
    waited = 0;
    while (!bus.m0_gnt && waited < 20) begin @(negedge clk); #1; waited++; end
    n_total++;
    if (bus.m0_gnt !== 1'b1) $display("FAIL m0_gnt a=%0d: got %b want 1", a, bus.m0_gnt); else n_pass++;
    wen_at_gnt = bus.mem_wen;
    @(posedge clk); #1;
    bus.m0_req = 1'b0;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    while (!got && lat < 4) begin
      @(negedge clk); lat++;
      if (bus.m0_rvalid) begin got = 1'b1; rd = bus.m0_rdata; er = bus.m0_err; end
    end
    n_total++;
    if (lat != 1) $display("FAIL m0_lat a=%0d: got %0d want 1", a, lat); else n_pass++;
    n_total++;
    if (rd !== exp_rd) $display("FAIL m0_rdata a=%0d: got %h want %h", a, rd, exp_rd); else n_pass++;
    n_total++;
    if (er !== exp_err) $display("FAIL m0_err a=%0d: got %b want %b", a, er, exp_err); else n_pass++;
    n_total++;
    if (wen_at_gnt !== 1'b0) $display("FAIL m0_wen_gnt a=%0d: got %b want 0", a, wen_at_gnt); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (bus.m0_gnt !== 1'b0)    $display("FAIL rst_m0_gnt: got %b want 0", bus.m0_gnt); else n_pass++;
    n_total++; if (bus.m1_gnt !== 1'b0)    $display("FAIL rst_m1_gnt: got %b want 0", bus.m1_gnt); else n_pass++;
    n_total++; if (bus.m0_rvalid !== 1'b0) $display("FAIL rst_m0_rvalid: got %b want 0", bus.m0_rvalid); else n_pass++;
    n_total++; if (bus.m1_rvalid !== 1'b0) $display("FAIL rst_m1_rvalid: got %b want 0", bus.m1_rvalid); else n_pass++;
    n_total++; if (bus.m0_rdata !== 32'h0) $display("FAIL rst_m0_rdata: got %h want 0", bus.m0_rdata); else n_pass++;
    n_total++; if (bus.m1_rdata !== 32'h0) $display("FAIL rst_m1_rdata: got %h want 0", bus.m1_rdata); else n_pass++;
    n_total++; if (bus.m0_err !== 1'b0)    $display("FAIL rst_m0_err: got %b want 0", bus.m0_err); else n_pass++;
    n_total++; if (bus.m1_err !== 1'b0)    $display("FAIL rst_m1_err: got %b want 0", bus.m1_err); else n_pass++;
    n_total++; if (bus.mem_wen !== 1'b0)   $display("FAIL rst_mem_wen: got %b want 0", bus.mem_wen); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); else n_pass++;
    rst = 1'b0;
    @(negedge clk); #1;
    n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL idle_mem_addr: got %h want 0", bus.mem_addr); else n_pass++;
  endtask

  task automatic test_contention();
    logic exp1;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_addr = 32'd0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_size = 2'd2; bus.m1_addr = 32'd4;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      exp1 = (c % 2 == 1);
`else
      exp1 = 1'b1;
`endif
      n_total++;
      if (bus.m1_gnt !== exp1 || bus.m0_gnt !== ~exp1)
        $display("FAIL contention_c%0d: got m0=%b m1=%b want m0=%b m1=%b", c, bus.m0_gnt, bus.m1_gnt, ~exp1, exp1);
      else n_pass++;
      @(negedge clk);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic er;
    m1_xact(1'b1, 2'd2, 32'd4, 32'hDEADBEEF, rd, er);
    m1_xact(1'b0, 2'd2, 32'd4, 32'h0, rd, er);
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL word_load: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_byte_rmw();
    logic [31:0] rd; logic er;
    m1_xact(1'b1, 2'd2, 32'd8, 32'h11223344, rd, er);
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_size = 2'd0; bus.m1_addr = 32'd8; bus.m1_wdata = 32'h5A5A5AAA;
    #1;
    n_total++; if (bus.m1_gnt !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 32'd8)
      $display("FAIL byte_gnt_cycle: got gnt=%b wen=%b addr=%h want 1 0 8", bus.m1_gnt, bus.mem_wen, bus.mem_addr); else n_pass++;
    ref_mem[8] = 8'hAA;
    @(posedge clk); #1;
    bus.m1_req = 1'b0; bus.m0_req = 1'b1; bus.m0_addr = 32'd8;
    @(negedge clk); #1;
    n_total++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0)
      $display("FAIL rmw_no_gnt: got m0=%b m1=%b want 0 0", bus.m0_gnt, bus.m1_gnt); else n_pass++;
    n_total++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'd8 || bus.mem_wdata !== 32'h112233AA)
      $display("FAIL rmw_write: got wen=%b addr=%h data=%h want 1 8 112233aa", bus.mem_wen, bus.mem_addr, bus.mem_wdata); else n_pass++;
    n_total++; if (bus.m1_rvalid !== 1'b0) $display("FAIL rmw_early_rvalid: got %b want 0", bus.m1_rvalid); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bus.m1_rvalid !== 1'b1 || bus.m1_err !== 1'b0)
      $display("FAIL byte_rvalid: got rvalid=%b err=%b want 1 0", bus.m1_rvalid, bus.m1_err); else n_pass++;
    n_total++; if (bus.m0_gnt !== 1'b1) $display("FAIL post_rmw_gnt: got %b want 1", bus.m0_gnt); else n_pass++;
    @(posedge clk); #1;
    bus.m0_req = 1'b0;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== ref_word(32'd8))
      $display("FAIL byte_fetch: got rvalid=%b data=%h want 1 %h", bus.m0_rvalid, bus.m0_rdata, ref_word(32'd8)); else n_pass++;
    n_total++; if (bus.m0_rdata !== 32'h112233AA) $display("FAIL byte_fetch_const: got %h want 112233aa", bus.m0_rdata); else n_pass++;
  endtask

  task automatic test_half_rmw();
    logic [31:0] rd; logic er;
    m1_xact(1'b1, 2'd2, 32'd8, 32'h11223344, rd, er);
    m1_xact(1'b1, 2'd1, 32'd8, 32'hFFFF5566, rd, er);
    m1_xact(1'b0, 2'd2, 32'd8, 32'h0, rd, er);
    n_total++; if (rd !== 32'h11225566) $display("FAIL half_readback: got %h want 11225566", rd); else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er;
    int wen_before;
    wen_before = wen_cnt;
    m1_xact(1'b1, 2'd2, 32'd29, 32'h12345678, rd, er);
    @(negedge clk); #3;
    n_total++; if (wen_cnt != wen_before) $display("FAIL range_wen: got %0d writes want 0", wen_cnt - wen_before); else n_pass++;
    n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL range_err: got err=%b rdata=%h want 1 0", er, rd); else n_pass++;
    m0_fetch(32'd28, rd, er);
    n_total++; if (er !== 1'b0) $display("FAIL fetch28_err: got %b want 0", er); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd;
    logic er, we;
    logic [1:0] sz;
    for (int n = 0; n < 40; n++) begin
      a  = 32'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 2) == 0) m0_fetch(a, rd, er);
      else m1_xact(we, sz, a, wd, rd, er);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er;
    int wen_before;
    m1_xact(1'b1, 2'd2, 32'd12, 32'hCAFEF00D, rd, er);
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_size = 2'd0; bus.m1_addr = 32'd12; bus.m1_wdata = 32'h000000AA;
    #1;
    n_total++; if (bus.m1_gnt !== 1'b1) $display("FAIL abort_gnt: got %b want 1", bus.m1_gnt); else n_pass++;
    wen_before = wen_cnt;
    @(posedge clk); #1;
    rst = 1'b1; bus.m1_req = 1'b0;
    #1;
    n_total++; if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
      $display("FAIL abort_mem: got wen=%b addr=%h data=%h want 0 0 0", bus.mem_wen, bus.mem_addr, bus.mem_wdata); else n_pass++;
    repeat (2) begin
      @(negedge clk);
      n_total++; if (bus.m1_rvalid !== 1'b0 || bus.mem_wen !== 1'b0)
        $display("FAIL abort_idle: got rvalid=%b wen=%b want 0 0", bus.m1_rvalid, bus.mem_wen); else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_total++; if (bus.m1_rvalid !== 1'b0 || wen_cnt != wen_before)
      $display("FAIL abort_after: got rvalid=%b writes=%0d want 0 0", bus.m1_rvalid, wen_cnt - wen_before); else n_pass++;
    m1_xact(1'b0, 2'd2, 32'd12, 32'h0, rd, er);
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL abort_readback: got %h want cafef00d", rd); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.m0_req = 1'b0; bus.m0_addr = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_size = '0; bus.m1_addr = '0; bus.m1_wdata = '0;

    test_reset();
    test_contention();
    test_word_store_load();
    test_byte_rmw();
    test_half_rmw();
    test_range();
    test_random();
    test_reset_abort();

    repeat (3) @(negedge clk);
    #3;
    n_total++; if (both_cnt != 0) $display("FAIL dual_gnt: got %0d cycles want 0", both_cnt); else n_pass++;
    n_total++; if (v0 != g0) $display("FAIL m0_resp_count: got %0d rvalid want %0d", v0, g0); else n_pass++;
    n_total++; if (v1 + 1 != g1) $display("FAIL m1_resp_count: got %0d rvalid want %0d", v1, g1 - 1); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
